// File: rtl/dma_p.sv
// Register-programmed single-channel memory-to-memory copy engine.
// Word-at-a-time read/write cycles through a shared local memory arbitrated by dma_req/dma_gnt.
module dma_p (
  input  logic        clk,
  input  logic        rst,
  input  logic        wea,
  input  logic [3:0]  addra,
  input  logic [31:0] dina,
  output logic [31:0] douta,
  output logic        dma_req,
  input  logic        dma_gnt,
  output logic        dma_we,
  output logic [13:0] dma_addr,
  output logic [31:0] dma_out,
  input  logic [31:0] dma_in,
  output logic        int_dma
);

  typedef enum logic [2:0] {IDLE, REQ, RD, WAIT, WR, DONE} state_t;

  typedef struct packed {
    logic [13:0] src;
    logic [13:0] dst;
    logic [11:0] cnt;
  } xfer_t;

  state_t      state, state_n;
  xfer_t       cfg, wrk;
  logic [31:0] data_r;
  logic        done, busy;
  logic        ctrl_wr, start, clr, advance;

  assign busy    = (state == REQ) || (state == RD) || (state == WAIT) || (state == WR);
  assign ctrl_wr = wea && (addra == 4'd3);
  assign start   = ctrl_wr && dina[0] && (state == IDLE);
  assign clr     = ctrl_wr && dina[1];
  assign advance = (state == WR) && dma_gnt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    dma_req  = 1'b0;
    dma_we   = 1'b0;
    dma_addr = '0;
    dma_out  = '0;
    int_dma  = 1'b0;
    case (state)
      IDLE: if (start) state_n = (cfg.cnt == '0) ? DONE : REQ;
      REQ: begin
        dma_req = 1'b1;
        if (dma_gnt) state_n = RD;
      end
      RD: begin
        dma_req  = 1'b1;
        dma_addr = wrk.src;
        if (dma_gnt) state_n = WAIT;
      end
      WAIT: begin
        dma_req = 1'b1;
        state_n = WR;
      end
      WR: begin
        dma_req  = 1'b1;
        dma_addr = wrk.dst;
        dma_out  = data_r;
        dma_we   = dma_gnt;
        if (dma_gnt) state_n = (wrk.cnt == 12'd1) ? DONE : RD;
      end
      DONE: begin
        int_dma = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Config registers are frozen for the whole transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg <= '0;
    end else if (wea && !busy) begin
      case (addra)
        4'd0: cfg.src <= dina[13:0];
        4'd1: cfg.dst <= dina[13:0];
        4'd2: cfg.cnt <= dina[11:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrk    <= '0;
      data_r <= '0;
    end else begin
      if (start) wrk <= cfg;
      if (state == WAIT) data_r <= dma_in;
      if (advance) begin
        wrk.src <= wrk.src + 14'd1;
        wrk.dst <= wrk.dst + 14'd1;
        wrk.cnt <= wrk.cnt - 12'd1;
      end
    end
  end

  // Set from DONE takes priority over a software clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst)                done <= 1'b0;
    else if (state == DONE) done <= 1'b1;
    else if (clr)           done <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      douta <= '0;
    end else begin
      case (addra)
        4'd0:    douta <= {18'b0, cfg.src};
        4'd1:    douta <= {18'b0, cfg.dst};
        4'd2:    douta <= {20'b0, cfg.cnt};
        4'd3:    douta <= {30'b0, done, busy};
        default: douta <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_p.sv
// Scoreboard bench for dma_p: expected memory writes are queued by the stimulus
// and consumed by a monitor; register/interrupt behaviour is checked directly.
module tb_dma_p;

  logic        clk = 1'b0;
  logic        rst, wea, dma_gnt;
  logic [3:0]  addra;
  logic [31:0] dina, douta, dma_out, dma_in;
  logic        dma_req, dma_we, int_dma;
  logic [13:0] dma_addr;

  typedef struct packed {
    logic [13:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] mem [0:16383];
  int          errors = 0;
  int          checks = 0;
  int          req_cycles = 0;
  int          int_cnt = 0;

  dma_p dut (
    .clk(clk), .rst(rst), .wea(wea), .addra(addra), .dina(dina), .douta(douta),
    .dma_req(dma_req), .dma_gnt(dma_gnt), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_out(dma_out), .dma_in(dma_in), .int_dma(int_dma)
  );

  always #5 clk = ~clk;

  // Local memory: 1-cycle read latency, mem[i] = 0x1000_0000 + i after reset.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16384; i++) mem[i] <= 32'h1000_0000 + i;
    end else begin
      dma_in <= mem[dma_addr];
      if (dma_we) mem[dma_addr] <= dma_out;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    wea = 1'b1; addra = a; dina = d;
    tick();
    wea = 1'b0;
  endtask

  task automatic rd(input string name, input logic [3:0] a, input logic [31:0] exp);
    addra = a;
    tick();
    chk(name, douta, exp);
  endtask

  task automatic push(input logic [13:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  // Counts edges until int_dma shows; optional grant stall: 5 edges in REQ, 2 in WR.
  task automatic wait_done(input string name, input int exp, input bit stall);
    int c = 0;
    while (!int_dma && c < 200) begin
      dma_gnt = !(stall && (c < 5 || c == 8 || c == 9));
      tick();
      c++;
    end
    dma_gnt = 1'b1;
    chk(name, c, exp);
    tick();
    chk({name, "_pulse"}, {31'b0, int_dma}, 32'd0);
  endtask

  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      if (dma_req) req_cycles++;
      if (int_dma) int_cnt++;
      if (dma_we) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: addr %h data %h, none expected", dma_addr, dma_out);
        end else begin
          e = exp_q.pop_front();
          if (dma_addr !== e.addr || dma_out !== e.data || dma_gnt !== 1'b1) begin
            errors++;
            $display("FAIL mem_write: got addr %h data %h gnt %b expected addr %h data %h gnt 1",
                     dma_addr, dma_out, dma_gnt, e.addr, e.data);
          end
        end
      end
    end
  endtask

  initial begin
    int rq, ic;
    rst = 1'b1; wea = 1'b0; addra = '0; dina = '0; dma_gnt = 1'b1;
    fork monitor(); join_none
    tick(); tick();
    chk("rst_douta", douta, 32'd0);
    chk("rst_outs", {27'b0, dma_req, dma_we, int_dma, 2'b0}, 32'd0);
    chk("rst_addr_out", {dma_addr, 18'b0} | dma_out, 32'd0);
    rst = 1'b0;
    rd("rst_status", 4'd3, 32'd0);
    rd("rst_src", 4'd0, 32'd0);

    // Register map
    wr(4'd0, 32'hFFFF_FFFF);
    rd("src_mask", 4'd0, 32'h0000_3FFF);
    wr(4'd2, 32'hFFFF_FFFF);
    rd("len_mask", 4'd2, 32'h0000_0FFF);
    wr(4'd9, 32'h1234_5678);
    rd("unmapped_rd", 4'd9, 32'd0);

    // Zero length; clear during the DONE cycle loses to set
    rq = req_cycles;
    wr(4'd2, 32'd0);
    wr(4'd3, 32'd1);
    chk("zero_int_next", {31'b0, int_dma}, 32'd1);
    wr(4'd3, 32'd2);
    rd("zero_status_setwins", 4'd3, 32'h2);
    chk("zero_no_req", req_cycles - rq, 32'd0);
    wr(4'd3, 32'd2);
    rd("done_clear", 4'd3, 32'd0);

    // Basic copy
    wr(4'd0, 32'h100); wr(4'd1, 32'h200); wr(4'd2, 32'd3);
    push(14'h200, 32'h1000_0100); push(14'h201, 32'h1000_0101); push(14'h202, 32'h1000_0102);
    wr(4'd3, 32'd1);
    wait_done("basic_latency", 10, 1'b0);
    rd("basic_status", 4'd3, 32'h2);
    wr(4'd3, 32'd2);

    // Busy protection
    wr(4'd0, 32'h10); wr(4'd1, 32'h20); wr(4'd2, 32'd3);
    push(14'h020, 32'h1000_0010); push(14'h021, 32'h1000_0011); push(14'h022, 32'h1000_0012);
    ic = int_cnt;
    wr(4'd3, 32'd1);
    wr(4'd1, 32'h50);
    wr(4'd3, 32'd1);
    rd("busy_status", 4'd3, 32'h1);
    wait_done("busy_latency", 7, 1'b0);
    repeat (4) tick();
    chk("busy_single_int", int_cnt - ic, 32'd1);
    rd("busy_dst_kept", 4'd1, 32'h20);
    wr(4'd3, 32'd2);

    // Grant stall: 5 + 2 extra cycles on a 2-word copy
    wr(4'd0, 32'h180); wr(4'd1, 32'h280); wr(4'd2, 32'd2);
    push(14'h280, 32'h1000_0180); push(14'h281, 32'h1000_0181);
    wr(4'd3, 32'd1);
    wait_done("stall_latency", 14, 1'b1);
    wr(4'd3, 32'd2);

    // Address wrap
    wr(4'd0, 32'h3FFF); wr(4'd1, 32'h3FFE); wr(4'd2, 32'd2);
    push(14'h3FFE, 32'h1000_3FFF); push(14'h3FFF, 32'h1000_0000);
    wr(4'd3, 32'd1);
    wait_done("wrap_latency", 7, 1'b0);
    wr(4'd3, 32'd2);

    // Reset during the second WAIT of a 4-word copy
    wr(4'd0, 32'h300); wr(4'd1, 32'h400); wr(4'd2, 32'd4);
    push(14'h400, 32'h1000_0300);
    ic = int_cnt;
    wr(4'd3, 32'd1);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    chk("abort_we", {31'b0, dma_we}, 32'd0);
    chk("abort_req", {31'b0, dma_req}, 32'd0);
    chk("abort_douta", douta, 32'd0);
    rst = 1'b0;
    repeat (12) tick();
    chk("abort_no_int", int_cnt - ic, 32'd0);
    rd("abort_status", 4'd3, 32'd0);
    rd("abort_src_cleared", 4'd0, 32'd0);
    chk("writes_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
